// File: rtl/nios2_freertos_switch_pio.sv
// nios2_freertos_switch_pio
//   Avalon-MM slave for a bank of board switches/keys. Each pin is
//   synchronised, debounced, and edge-detected. Edges latch into a sticky
//   EDGECAPTURE register, and a masked level IRQ is raised to the Nios II.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     word address: 0 DATA, 1 IRQMASK, 2 reserved, 3 EDGECAPTURE
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one-cycle latency, zero-extended
//   in_port     raw pins, asynchronous to clk
//   irq         level interrupt: |(edgecapture & irqmask)
module nios2_freertos_switch_pio #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_d_prev;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Upper writedata bits have no destination when WIDTH < 32.
  assign w_unused = &{1'b0, writedata};

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_no_filter
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_d <= '0;
        end else begin
          r_d <= w_s;
        end
      end
    end else begin : g_filter
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt [WIDTH];

      // Counter only advances while s differs from d, so it restarts on any
      // glitch and stops at CNT_LAST when the new level is taken.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_d <= '0;
          for (int unsigned b = 0; b < WIDTH; b++) begin
            r_cnt[b] <= '0;
          end
        end else begin
          for (int unsigned b = 0; b < WIDTH; b++) begin
            if (w_s[b] == r_d[b]) begin
              r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_LAST) begin
              r_d[b]   <= w_s[b];
              r_cnt[b] <= '0;
            end else begin
              r_cnt[b] <= r_cnt[b] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detect
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_prev <= '0;
    end else begin
      r_d_prev <= r_d;
    end
  end

  assign w_rise = r_d & ~r_d_prev;
  assign w_fall = ~r_d & r_d_prev;

  always_comb begin
    w_edge_set = w_rise | w_fall;
    case (EDGE_TYPE)
      0:       w_edge_set = w_rise;
      1:       w_edge_set = w_fall;
      default: w_edge_set = w_rise | w_fall;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && address == 2'd1) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // Set is OR'd in after the clear so a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_edge_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_d;
      2'd1:    w_rdata[WIDTH-1:0] = r_mask;
      2'd3:    w_rdata[WIDTH-1:0] = r_edge;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule
